bcd_scan_display: RTL and testbench
===================================

# bcd_scan_display

Parametrised, time-multiplexed multi-digit BCD-to-seven-segment driver. It latches a packed NUM_DIGITS-wide BCD word plus decimal points and scans one digit at a time onto a shared segment bus with one-hot digit enables. It supports leading-zero blanking and output polarity selection. It sits between datapath logic and the board's common-anode display, replacing per-digit combinational decoders.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 100000, clk cycles each digit stays enabled (>=2)
- ACTIVE_LOW, 1, 1: seg/dp/an driven low-true; 0: high-true
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- bcd_in  input  4*NUM_DIGITS  packed BCD; digit i = bcd_in[4i+3:4i], digit 0 least significant
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
- load  input  1  latch bcd_in/dp_in on this edge
- blank_lz  input  1  1 = enable leading-zero blanking
- seg  output  7  segments {g,f,e,d,c,b,a}, seg[0]=a
- dp  output  1  decimal point of active digit
- an  output  NUM_DIGITS  one-hot digit enable
- frame  output  1  one-cycle pulse when scan wraps to digit 0

## Operation
- Latch: on an edge with load=1, val_q<=bcd_in and dp_q<=dp_in. Otherwise both hold. Reset value is 0 for both.
- Refresh counter cnt: 0..REFRESH_DIV-1, +1 per cycle. At REFRESH_DIV-1 it wraps to 0, and the digit index idx advances.
- idx: 0..NUM_DIGITS-1, wraps NUM_DIGITS-1 -> 0. Width is clog2(NUM_DIGITS), minimum 1.
- Decode of the nibble at idx (active-high pattern, g..a):
  - 0 = 0111111
  - 1 = 0000110
  - 2 = 1011011
  - 3 = 1001111
  - 4 = 1100110
  - 5 = 1101101
  - 6 = 1111101
  - 7 = 0000111
  - 8 = 1111111
  - 9 = 1101111
  - codes 10-15 = 1000000 (dash)
- Leading-zero blanking: digit i>0 is blank when blank_lz=1 and nibbles i..NUM_DIGITS-1 of val_q are all 0.
  - Blank means all segments off. dp still follows dp_q[i].
  - Digit 0 is never blanked.
  - blank_lz is sampled live, not latched.
- Polarity: when ACTIVE_LOW=1, seg, dp and an are bitwise inverted at the output register.
- State: the block has no FSM beyond cnt/idx. Scanning is free-running from reset and never stalls.

## Timing
- seg, dp, an and frame are all registered.
  - Outputs reflect the idx/val_q/dp_q/blank_lz values of the previous cycle: latency 1 clk.
- Reset (asynchronous assert, synchronous release effect on next edge):
  - cnt=0, idx=0, val_q=0, dp_q=0.
  - All outputs inactive: seg all off, dp off, an all off, frame=0. With ACTIVE_LOW=1 this is seg=7'h7F, dp=1, an all 1s.
- First clk edge after reset release: an enables digit 0, showing val_q digit 0.
- Each digit is enabled for exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- frame=1 for exactly one cycle: the cycle in which an first shows digit 0 after a wrap. It is not asserted after reset.
- load during a scan: the new value appears on the next output update (1 cycle later), mid-digit if applicable. No waiting for frame.
- load held high: the latch re-captures every cycle.
- rst asserted mid-scan: outputs go inactive immediately (asynchronously). Scanning restarts at digit 0.
- NUM_DIGITS=1: idx is constant 0, an is always enabled after reset, and frame pulses every REFRESH_DIV cycles.

## Test plan
Common setup: NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.

- **Reset values.** Hold rst for 3 cycles -> seg=7'h7F, dp=1, an=4'b1111, frame=0 throughout. After release, the next edge gives an=4'b1110 and seg=7'h40 (digit "0").
- **Scan and load.** load=1 with bcd_in=16'h1234, dp_in=4'b0100, blank_lz=0 -> required output sequence:
  - an=1110, seg=7'h19 (4) for 4 cycles
  - then an=1101, seg=7'h30 (3)
  - then an=1011, seg=7'h24 (2), dp=0
  - then an=0111, seg=7'h79 (1)
  - then frame=1 for one cycle as an returns to 1110.
- **Leading-zero blanking.** bcd_in=16'h0070, blank_lz=1 -> digits 3 and 2 give seg=7'h7F; digit 1 gives seg=7'h78 (7); digit 0 gives seg=7'h40. With blank_lz=0, digits 3 and 2 give 7'h40.
- **Invalid codes.** bcd_in=16'hFA00 -> digits 3 and 2 give seg=7'h3F (dash). With blank_lz=1, these are not blanked.
- **Reset mid-scan.** Assert rst while an=1011 -> outputs go inactive within the same cycle, without waiting for a clk edge. After release, scanning restarts at an=1110 with val_q=0.
- **Polarity and width variants.** ACTIVE_LOW=0, NUM_DIGITS=1, bcd_in=4'h8 -> an=1'b1, seg=7'h7F, frame every 4 cycles.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Time-multiplexed multi-digit BCD to seven-segment scanner with leading-zero
// blanking and selectable output polarity; all outputs registered.
module bcd_scan_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = NIB_W * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_POL  = {SEG_W{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_POL   = {NUM_DIGITS{ACTIVE_LOW}};

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [BCD_W-1:0]      r_val;
  logic [NUM_DIGITS-1:0] r_dpq;
  logic                  r_frame_pend;
  logic [SEG_W-1:0]      r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame;

  logic                  w_cnt_last;
  logic                  w_idx_last;
  logic [NIB_W-1:0]      w_nib;
  logic                  w_dp_sel;
  logic                  w_blank;
  logic [SEG_W-1:0]      w_pat;
  logic [NUM_DIGITS-1:0] w_an_hot;

  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_idx_last = (r_idx == IDX_LAST);
  assign w_an_hot   = NUM_DIGITS'(1) << r_idx;

  // Refresh counter and digit index, free-running from reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_pend <= 1'b0;
    end else begin
      r_frame_pend <= w_cnt_last && w_idx_last;
      if (w_cnt_last) begin
        r_cnt <= '0;
        r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= '0;
      r_dpq <= '0;
    end else if (load) begin
      r_val <= bcd_in;
      r_dpq <= dp_in;
    end
  end

  // Digit select; a digit is blank when it and every more significant nibble are zero
  always_comb begin
    w_nib    = '0;
    w_dp_sel = 1'b0;
    w_blank  = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib    = r_val[NIB_W*i +: NIB_W];
        w_dp_sel = r_dpq[i];
        w_blank  = (i > 0) && blank_lz && ((r_val >> (NIB_W*i)) == '0);
      end
    end
  end

  always_comb begin
    w_pat = 7'b1000000;
    unique case (w_nib)
      4'd0:    w_pat = 7'b0111111;
      4'd1:    w_pat = 7'b0000110;
      4'd2:    w_pat = 7'b1011011;
      4'd3:    w_pat = 7'b1001111;
      4'd4:    w_pat = 7'b1100110;
      4'd5:    w_pat = 7'b1101101;
      4'd6:    w_pat = 7'b1111101;
      4'd7:    w_pat = 7'b0000111;
      4'd8:    w_pat = 7'b1111111;
      4'd9:    w_pat = 7'b1101111;
      default: w_pat = 7'b1000000;
    endcase
  end

  // Output register with polarity applied; reset value is the inactive level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg   <= SEG_POL;
      r_dp    <= ACTIVE_LOW;
      r_an    <= AN_POL;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= (w_blank ? '0 : w_pat) ^ SEG_POL;
      r_dp    <= w_dp_sel ^ ACTIVE_LOW;
      r_an    <= w_an_hot ^ AN_POL;
      r_frame <= r_frame_pend;
    end
  end

  assign seg   = r_seg;
  assign dp    = r_dp;
  assign an    = r_an;
  assign frame = r_frame;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed scenarios plus randomized
// traffic against a frame-position reference model.
module tb_bcd_scan_display;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  logic        rst1;
  logic [3:0]  bcd1;
  logic [0:0]  dp1_in;
  logic        load1;
  logic        blank1;
  logic [6:0]  seg1;
  logic        dp1;
  logic [0:0]  an1;
  logic        frame1;

  bcd_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  bcd_scan_display #(.NUM_DIGITS(1), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .bcd_in(bcd1), .dp_in(dp1_in), .load(load1),
    .blank_lz(blank1), .seg(seg1), .dp(dp1), .an(an1), .frame(frame1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_val;
  logic [3:0]  m_dp;
  int unsigned m_edges;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_frame;

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Reference model: digit shown after edge n (n from 0) is (n/RD)%ND, computed
  // from the latched word and live blank_lz as seen just before the edge.
  task automatic step();
    int unsigned d;
    logic [3:0] nib;
    logic blank;
    d = (m_edges / RD) % ND;
    nib = 4'(m_val >> (4*d));
    blank = blank_lz && (d > 0) && ((m_val >> (4*d)) == 16'h0);
    exp_seg = ~(blank ? 7'h00 : pat(nib));
    exp_dp = ~m_dp[d];
    exp_an = 4'b1111 ^ (4'b0001 << d);
    exp_frame = (m_edges > 0) && ((m_edges % (ND*RD)) == 0);
    @(posedge clk);
    if (load) begin
      m_val = bcd_in;
      m_dp = dp_in;
    end
    m_edges++;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_val = '0;
    m_dp = '0;
    m_edges = 0;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < int'(ND*RD) + 2; n++) begin
      step();
      if (exp_frame) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load = 1'b0;
    blank_lz = 1'b0;
    bcd_in = 16'h0;
    dp_in = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'b1111 || frame !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: seg=%h dp=%b an=%b frame=%b, expected 7f 1 1111 0", seg, dp, an, frame);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    m_val = '0; m_dp = '0; m_edges = 0;
    step();
    checks++;
    if (an !== 4'b1110 || seg !== 7'h40 || frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge: an=%b seg=%h frame=%b, expected 1110 40 0", an, seg, frame);
    end
  endtask

  // Check one full frame against per-digit constants, starting at a frame pulse
  task automatic test_scan_load();
    logic [6:0] segs [4];
    bit ok;
    int unsigned d;
    segs = '{7'h19, 7'h30, 7'h24, 7'h79};
    apply_reset();
    bcd_in = 16'h1234; dp_in = 4'b0100; blank_lz = 1'b0; load = 1'b1;
    wait_frame(ok);
    load = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL scan_wait_frame: no frame within bound, expected one"); end
    for (int j = 0; j < 16; j++) begin
      if (j > 0) step();
      d = j / 4;
      checks++;
      if (an !== (4'b1111 ^ (4'b0001 << d)) || seg !== segs[d] || dp !== (d != 2) ||
          frame !== (j == 0)) begin
        errors++;
        $display("FAIL scan_load j=%0d: an=%b seg=%h dp=%b frame=%b, expected digit %0d seg %h", j, an, seg, dp, frame, d, segs[d]);
      end
    end
    step();
    checks++;
    if (frame !== 1'b1 || an !== 4'b1110) begin
      errors++;
      $display("FAIL scan_wrap: frame=%b an=%b, expected 1 1110", frame, an);
    end
  endtask

  task automatic check_frame_segs(input string name, input logic [6:0] s0, input logic [6:0] s1,
                                  input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] segs [4];
    bit ok;
    segs = '{s0, s1, s2, s3};
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_wait: no frame within bound", name); end
    for (int j = 0; j < 16; j++) begin
      if (j > 0) step();
      checks++;
      if (seg !== segs[j/4]) begin
        errors++;
        $display("FAIL %s j=%0d: seg=%h, expected %h", name, j, seg, segs[j/4]);
      end
    end
  endtask

  task automatic test_lz_blanking();
    apply_reset();
    bcd_in = 16'h0070; dp_in = 4'h0; blank_lz = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    check_frame_segs("lz_on", 7'h40, 7'h78, 7'h7F, 7'h7F);
    blank_lz = 1'b0;
    check_frame_segs("lz_off", 7'h40, 7'h78, 7'h40, 7'h40);
  endtask

  task automatic test_invalid_codes();
    apply_reset();
    bcd_in = 16'hFA00; dp_in = 4'h0; blank_lz = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    check_frame_segs("invalid", 7'h40, 7'h40, 7'h3F, 7'h3F);
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    apply_reset();
    bcd_in = 16'h1234; dp_in = 4'b0100; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      step();
      ok = (an === 4'b1011);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_wait: an never 1011"); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'b1111 || frame !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: seg=%h dp=%b an=%b frame=%b, expected 7f 1 1111 0", seg, dp, an, frame);
    end
    @(negedge clk);
    rst = 1'b0;
    m_val = '0; m_dp = '0; m_edges = 0;
    step();
    checks++;
    if (an !== 4'b1110 || seg !== 7'h40 || dp !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart: an=%b seg=%h dp=%b, expected 1110 40 1", an, seg, dp);
    end
  endtask

  // Random loads (including held load), invalid codes, zero-heavy words, live blank_lz
  task automatic test_random();
    logic [15:0] masks [5];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      load = (c < 40) ? 1'b1 : ($urandom_range(0, 3) == 0);
      bcd_in = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp_in = 4'($urandom);
      if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
      step();
      checks++;
      if (seg !== exp_seg || dp !== exp_dp || an !== exp_an || frame !== exp_frame) begin
        errors++;
        $display("FAIL random c=%0d: seg=%h dp=%b an=%b frame=%b, expected %h %b %b %b", c, seg, dp, an, frame, exp_seg, exp_dp, exp_an, exp_frame);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_single_digit_high();
    checks++;
    if (seg1 !== 7'h00 || dp1 !== 1'b0 || an1 !== 1'b0 || frame1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_reset: seg=%h dp=%b an=%b frame=%b, expected 00 0 0 0", seg1, dp1, an1, frame1);
    end
    @(negedge clk);
    rst1 = 1'b0;
    bcd1 = 4'h8; dp1_in = 1'b0; load1 = 1'b1; blank1 = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (an1 !== 1'b1 || dp1 !== 1'b0 || (k >= 2 && seg1 !== 7'h7F) ||
          frame1 !== (k > 1 && ((k - 1) % 4) == 0)) begin
        errors++;
        $display("FAIL w1_scan k=%0d: an=%b seg=%h dp=%b frame=%b", k, an1, seg1, dp1, frame1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0;
    load1 = 1'b0; bcd1 = '0; dp1_in = '0; blank1 = 1'b0;
    m_val = '0; m_dp = '0; m_edges = 0;
    #1;
    test_reset();
    test_scan_load();
    test_lz_blanking();
    test_invalid_codes();
    test_reset_mid_scan();
    test_random();
    test_single_digit_high();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
